// File: rtl/tdma_pkg.sv
// Shared types and constants for the TDMA slot scheduler.
// Contents:
//   sched_state_t  scheduler FSM state (IDLE, WAIT_SYNC, RUN)
//   tdma_cfg_t     one configuration shadow (tx_slot, rx_slot, tpuint)
//   CTRL_*_BIT     bit positions inside the control register
//   slot_valid()   true when a configured slot exists in the frame
package tdma_pkg;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MASTER_BIT = 1;

    // Field widths of a configuration shadow; the scheduler's SLOT_W/TICK_W
    // default to these and must stay equal to them.
    localparam int CFG_SLOT_W = 8;
    localparam int CFG_TICK_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [CFG_SLOT_W-1:0] tx_slot;
        logic [CFG_SLOT_W-1:0] rx_slot;
        logic [CFG_TICK_W-1:0] tpuint;
    } tdma_cfg_t;

    // A slot number at or beyond the frame length can never match the slot counter.
    function automatic logic slot_valid(input logic [CFG_SLOT_W-1:0] slot,
                                        input int num_slots);
        return (32'(slot) < 32'(num_slots));
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Tick and slot counters for the TDMA frame.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          hold counters and pulses at zero (scheduler not running)
//   start          restart the frame: slot 0, tick 0, frame_start next cycle
//   tpuint         cycles per slot of the active configuration (0 acts as 1)
//   slot_idx_nxt   value slot_idx takes at the next edge
//   frame_nxt      frame_start takes this value at the next edge
//   slot_idx       current slot (registered)
//   slot_tick      first cycle of every slot (registered)
//   frame_start    first cycle of slot 0 (registered)
module slot_timer #(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 8,
    parameter int TICK_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [TICK_W-1:0] tpuint,
    output logic [SLOT_W-1:0] slot_idx_nxt,
    output logic              frame_nxt,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              slot_tick,
    output logic              frame_start
);

    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_nxt_s;
    logic [TICK_W-1:0] tick_last_s;
    logic              slot_tick_nxt_s;

    // Next counter values: clear, frame restart, or normal advance with wrap.
    always_comb begin
        tick_nxt_s      = tick_r;
        slot_idx_nxt    = slot_idx;
        frame_nxt       = 1'b0;
        slot_tick_nxt_s = 1'b0;
        if (tpuint == TICK_ZERO) begin
            tick_last_s = TICK_ZERO;
        end else begin
            tick_last_s = tpuint - TICK_ONE;
        end
        if (clear) begin
            tick_nxt_s   = TICK_ZERO;
            slot_idx_nxt = SLOT_ZERO;
        end else if (start) begin
            tick_nxt_s      = TICK_ZERO;
            slot_idx_nxt    = SLOT_ZERO;
            frame_nxt       = 1'b1;
            slot_tick_nxt_s = 1'b1;
        end else if (tick_r >= tick_last_s) begin
            // >= rather than == keeps the counter bounded whatever tpuint does.
            tick_nxt_s      = TICK_ZERO;
            slot_tick_nxt_s = 1'b1;
            if (slot_idx == SLOT_LAST) begin
                slot_idx_nxt = SLOT_ZERO;
                frame_nxt    = 1'b1;
            end else begin
                slot_idx_nxt = slot_idx + SLOT_ONE;
            end
        end else begin
            tick_nxt_s = tick_r + TICK_ONE;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r      <= TICK_ZERO;
            slot_idx    <= SLOT_ZERO;
            slot_tick   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            tick_r      <= tick_nxt_s;
            slot_idx    <= slot_idx_nxt;
            slot_tick   <= slot_tick_nxt_s;
            frame_start <= frame_nxt;
        end
    end

endmodule

// File: rtl/tdma_slot_scheduler.sv
// TDMA slot scheduler: FSM, configuration shadows, window decode and TX overrun.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ctrl_en, ctrl_master          control register bits (enable, master/slave)
//   cfg_tx_slot/rx_slot/tpuint    configuration register values
//   cfg_update                    pulse: capture cfg_* into the pending shadow
//   sync_in                       pulse: external frame sync (slave)
//   tx_done                       pulse: TX datapath finished
//   slot_idx, frame_start, slot_tick                frame timing (registered)
//   tx_window, rx_window, tx_start, rx_start        datapath windows (registered)
//   err_overrun                   sticky TX overrun, cleared by disable
//   running                       scheduler is in RUN
// All outputs are registers updated from the same next-state values, so
// windows stay aligned with slot_idx.
module tdma_slot_scheduler
    import tdma_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = CFG_SLOT_W,
    parameter int TICK_W    = CFG_TICK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_en,
    input  logic              ctrl_master,
    input  logic [SLOT_W-1:0] cfg_tx_slot,
    input  logic [SLOT_W-1:0] cfg_rx_slot,
    input  logic [TICK_W-1:0] cfg_tpuint,
    input  logic              cfg_update,
    input  logic              sync_in,
    input  logic              tx_done,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              frame_start,
    output logic              slot_tick,
    output logic              tx_window,
    output logic              rx_window,
    output logic              tx_start,
    output logic              rx_start,
    output logic              err_overrun,
    output logic              running
);

    sched_state_t      state_r, state_nxt_s;
    tdma_cfg_t         act_r, pend_r, cfg_eff_s, cfg_in_s;
    logic [1:0]        ctrl_s;
    logic              run_nxt_s, resync_s, start_s, clear_s;
    logic [SLOT_W-1:0] slot_nxt_s;
    logic              frame_nxt_s;
    logic              tx_hit_s, rx_hit_s, tx_start_nxt_s, rx_start_nxt_s;
    logic              tx_end_s, tx_pending_r, tx_pending_nxt_s, err_nxt_s;
    logic              tx_window_r, rx_window_r, tx_start_r, rx_start_r;
    logic              err_overrun_r, running_r;

    // Control register view and incoming configuration word.
    always_comb begin
        ctrl_s                  = 2'b00;
        ctrl_s[CTRL_EN_BIT]     = ctrl_en;
        ctrl_s[CTRL_MASTER_BIT] = ctrl_master;
        cfg_in_s = '{tx_slot: cfg_tx_slot, rx_slot: cfg_rx_slot, tpuint: cfg_tpuint};
    end

    // FSM next state and frame-restart requests for the timer.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (ctrl_s[CTRL_EN_BIT]) begin
                    state_nxt_s = ctrl_s[CTRL_MASTER_BIT] ? RUN : WAIT_SYNC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_SYNC: begin
                if (!ctrl_s[CTRL_EN_BIT]) begin
                    state_nxt_s = IDLE;
                end else if (sync_in) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WAIT_SYNC;
                end
            end
            RUN: begin
                state_nxt_s = ctrl_s[CTRL_EN_BIT] ? RUN : IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        run_nxt_s = (state_nxt_s == RUN);
        // A slave already running realigns to an external sync.
        resync_s  = (state_r == RUN) && run_nxt_s && sync_in && !ctrl_s[CTRL_MASTER_BIT];
        start_s   = run_nxt_s && ((state_r != RUN) || resync_s);
        clear_s   = !run_nxt_s;
    end

    slot_timer #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .TICK_W    (TICK_W)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_s),
        .start        (start_s),
        .tpuint       (act_r.tpuint),
        .slot_idx_nxt (slot_nxt_s),
        .frame_nxt    (frame_nxt_s),
        .slot_idx     (slot_idx),
        .slot_tick    (slot_tick),
        .frame_start  (frame_start)
    );

    // Window decode against the config that will be active next cycle, plus
    // TX transfer tracking. A window that stays open (e.g. resync inside the
    // same slot) produces no second start pulse.
    always_comb begin
        cfg_eff_s = frame_nxt_s ? pend_r : act_r;
        tx_hit_s  = run_nxt_s && slot_valid(cfg_eff_s.tx_slot, NUM_SLOTS)
                    && (slot_nxt_s == cfg_eff_s.tx_slot);
        rx_hit_s  = run_nxt_s && slot_valid(cfg_eff_s.rx_slot, NUM_SLOTS)
                    && (slot_nxt_s == cfg_eff_s.rx_slot)
                    && (cfg_eff_s.rx_slot != cfg_eff_s.tx_slot);
        tx_start_nxt_s = tx_hit_s && !tx_window_r;
        rx_start_nxt_s = rx_hit_s && !rx_window_r;
        tx_end_s       = tx_window_r && !tx_hit_s;
        if (!run_nxt_s) begin
            tx_pending_nxt_s = 1'b0;
            err_nxt_s        = 1'b0;
        end else begin
            // tx_done seen on the last window cycle still counts as on time.
            err_nxt_s = err_overrun_r || (tx_end_s && tx_pending_r && !tx_done);
            if (tx_start_nxt_s) begin
                tx_pending_nxt_s = 1'b1;
            end else if (tx_end_s || tx_done) begin
                tx_pending_nxt_s = 1'b0;
            end else begin
                tx_pending_nxt_s = tx_pending_r;
            end
        end
    end

    // FSM state, config shadows and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            act_r         <= '{tx_slot: 8'd0, rx_slot: 8'd0, tpuint: 16'd0};
            pend_r        <= '{tx_slot: 8'd0, rx_slot: 8'd0, tpuint: 16'd0};
            running_r     <= 1'b0;
            tx_window_r   <= 1'b0;
            rx_window_r   <= 1'b0;
            tx_start_r    <= 1'b0;
            rx_start_r    <= 1'b0;
            tx_pending_r  <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            // Apply uses the old pending value; a same-cycle update waits a frame.
            act_r         <= frame_nxt_s ? pend_r : act_r;
            pend_r        <= cfg_update ? cfg_in_s : pend_r;
            running_r     <= run_nxt_s;
            tx_window_r   <= tx_hit_s;
            rx_window_r   <= rx_hit_s;
            tx_start_r    <= tx_start_nxt_s;
            rx_start_r    <= rx_start_nxt_s;
            tx_pending_r  <= tx_pending_nxt_s;
            err_overrun_r <= err_nxt_s;
        end
    end

    assign tx_window   = tx_window_r;
    assign rx_window   = rx_window_r;
    assign tx_start    = tx_start_r;
    assign rx_start    = rx_start_r;
    assign err_overrun = err_overrun_r;
    assign running     = running_r;

endmodule

// File: tb/tb_tdma_slot_scheduler.sv
// Self-checking bench for tdma_slot_scheduler (NUM_SLOTS=4).
// Each cycle a frame-position model predicts the outputs and pushes them to a
// queue; the sampled DUT outputs go to a second queue. Each test task drains
// both and compares, adding scenario-specific checks from fixed cycle numbers.
// Output word: {slot_idx[7:0], frame_start, slot_tick, tx_window, rx_window,
//               tx_start, rx_start, err_overrun, running}
module tb_tdma_slot_scheduler;

    localparam int NS = 4;

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic [15:0] tp;
    } mcfg_t;

    logic        clk = 1'b0;
    logic        rst, ctrl_en, ctrl_master, cfg_update, sync_in, tx_done;
    logic [7:0]  cfg_tx_slot, cfg_rx_slot;
    logic [15:0] cfg_tpuint;
    logic [7:0]  slot_idx;
    logic        frame_start, slot_tick, tx_window, rx_window;
    logic        tx_start, rx_start, err_overrun, running;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    // model state
    int    m_state;   // 0 idle, 1 waiting for sync, 2 running
    int    m_pos;     // cycle within the current frame
    int    m_T;       // cycles per slot in the current frame
    mcfg_t m_act, m_pend;
    logic  m_ptx, m_prx, m_busy, m_err;
    logic [15:0] m_exp;

    always #5 clk = ~clk;

    tdma_slot_scheduler #(.NUM_SLOTS(NS), .SLOT_W(8), .TICK_W(16)) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_master(ctrl_master),
        .cfg_tx_slot(cfg_tx_slot), .cfg_rx_slot(cfg_rx_slot), .cfg_tpuint(cfg_tpuint),
        .cfg_update(cfg_update), .sync_in(sync_in), .tx_done(tx_done),
        .slot_idx(slot_idx), .frame_start(frame_start), .slot_tick(slot_tick),
        .tx_window(tx_window), .rx_window(rx_window), .tx_start(tx_start),
        .rx_start(rx_start), .err_overrun(err_overrun), .running(running)
    );

    task automatic model_step();
        int   slot, tick;
        logic fs, st, tw, rw, ts, rs, fresh;
        slot = 0; tick = 0; fs = 0; st = 0; tw = 0; rw = 0; ts = 0; rs = 0; fresh = 0;
        if (rst) begin
            m_state = 0; m_pos = 0; m_T = 1; m_act = '0; m_pend = '0;
            m_ptx = 0; m_prx = 0; m_busy = 0; m_err = 0;
        end else begin
            if (!ctrl_en) m_state = 0;
            else if (m_state == 0) begin
                if (ctrl_master) begin m_state = 2; fresh = 1; end
                else m_state = 1;
            end else if (m_state == 1) begin
                if (sync_in) begin m_state = 2; fresh = 1; end
            end else if (sync_in && !ctrl_master) fresh = 1;

            if (m_state == 2) begin
                if (fresh) m_pos = 0;
                else begin
                    m_pos = m_pos + 1;
                    if (m_pos >= NS * m_T) m_pos = 0;
                end
                if (m_pos == 0) begin
                    m_act = m_pend;
                    m_T = (m_act.tp == 16'd0) ? 1 : int'(m_act.tp);
                end
                slot = m_pos / m_T;
                tick = m_pos % m_T;
                fs = (m_pos == 0);
                st = (tick == 0);
                tw = (slot == int'(m_act.tx));
                rw = (slot == int'(m_act.rx)) && (m_act.rx != m_act.tx);
                ts = tw && !m_ptx;
                rs = rw && !m_prx;
                if (m_ptx && !tw) begin
                    if (m_busy && !tx_done) m_err = 1;
                    m_busy = 0;
                end else if (tx_done) m_busy = 0;
                if (ts) m_busy = 1;
                m_ptx = tw; m_prx = rw;
            end else begin
                m_pos = 0; m_ptx = 0; m_prx = 0; m_busy = 0; m_err = 0;
            end
            if (cfg_update) m_pend = '{tx: cfg_tx_slot, rx: cfg_rx_slot, tp: cfg_tpuint};
        end
        m_exp = {8'(slot), fs, st, tw, rw, ts, rs, m_err, (m_state == 2)};
    endtask

    // One clock: predict, clock, sample, drop the single-cycle pulses.
    task automatic cycle();
        model_step();
        exp_q.push_back(m_exp);
        @(posedge clk);
        #1;
        obs_q.push_back({slot_idx, frame_start, slot_tick, tx_window, rx_window,
                         tx_start, rx_start, err_overrun, running});
        cfg_update = 1'b0; sync_in = 1'b0; tx_done = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] tx, input logic [7:0] rx, input logic [15:0] tp);
        cfg_tx_slot = tx; cfg_rx_slot = rx; cfg_tpuint = tp; cfg_update = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] e, o;
        for (int j = 0; j < 4; j++) begin
            rst = (j < 3); ctrl_en = 1'b0; ctrl_master = 1'b1;
            cycle();
        end
        for (int j = 0; j < 4; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL reset_sb[%0d]: got %h want %h", j, o, e); end
            vectors++;
            if (o !== 16'h0000) begin miscompares++; $display("FAIL reset_zero[%0d]: got %h want 0000", j, o); end
        end
    endtask

    task automatic test_master();
        logic [15:0] e, o;
        int k;
        logic [5:0] want;
        for (int j = -1; j < 36; j++) begin
            if (j < 0) begin ctrl_en = 1'b0; ctrl_master = 1'b1; set_cfg(8'd1, 8'd2, 16'd3); end
            else begin ctrl_en = 1'b1; tx_done = (j % 12 == 6); end
            cycle();
        end
        for (int j = -1; j < 36; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL master_sb[%0d]: got %h want %h", j, o, e); end
            if (j >= 0) begin
                k = j % 12;
                // {frame_start, tx_window, rx_window, tx_start, rx_start, err_overrun}
                want = {k == 0, k >= 3 && k <= 5, k >= 6 && k <= 8, k == 3, k == 6, 1'b0};
                vectors++;
                if ({o[7], o[5:1]} !== want) begin
                    miscompares++;
                    $display("FAIL master_spec[%0d]: got %b want %b", j, {o[7], o[5:1]}, want);
                end
            end
        end
    endtask

    task automatic test_slave();
        logic [15:0] e, o;
        for (int j = -1; j < 20; j++) begin
            ctrl_en = (j >= 0); ctrl_master = 1'b0;
            sync_in = (j == 7) || (j == 13);
            cycle();
        end
        for (int j = -1; j < 20; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL slave_sb[%0d]: got %h want %h", j, o, e); end
            if (j >= 0 && j <= 13) begin
                // {running, frame_start, slot_idx}
                vectors++;
                if ({o[0], o[7], o[15:8]} !== {j >= 7, j == 7 || j == 13,
                                               8'((j >= 7 && j < 13) ? (j - 7) / 3 : 0)}) begin
                    miscompares++;
                    $display("FAIL slave_spec[%0d]: got run=%b fs=%b slot=%0d", j, o[0], o[7], o[15:8]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [15:0] e, o;
        for (int j = -1; j < 55; j++) begin
            ctrl_en = (j >= 0) && (j != 30); ctrl_master = 1'b1;
            tx_done = (j >= 31) && ((j - 31) % 12 == 6);
            cycle();
        end
        for (int j = -1; j < 55; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL overrun_sb[%0d]: got %h want %h", j, o, e); end
            if (j >= 0) begin
                vectors++;
                if (o[1] !== (j >= 6 && j < 30)) begin
                    miscompares++;
                    $display("FAIL overrun_spec[%0d]: got err=%b want %b", j, o[1], (j >= 6 && j < 30));
                end
            end
            if (j == 30) begin
                vectors++;
                if (o !== 16'h0000) begin miscompares++; $display("FAIL overrun_clear: got %h want 0000", o); end
            end
        end
    endtask

    task automatic test_cfg();
        logic [15:0] e, o;
        logic        wtx, wrx;
        for (int j = -1; j < 48; j++) begin
            ctrl_en = (j >= 0); ctrl_master = 1'b1;
            if (j == 4)  set_cfg(8'd3, 8'd2, 16'd3);
            if (j == 24) set_cfg(8'd2, 8'd2, 16'd0);
            cycle();
        end
        for (int j = -1; j < 48; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL cfg_sb[%0d]: got %h want %h", j, o, e); end
            if (j >= 0) begin
                if (j < 12) wtx = (j >= 3 && j <= 5);
                else if (j < 36) wtx = ((j % 12) >= 9);
                else wtx = ((j - 36) % 4 == 2);
                wrx = (j < 36) && ((j % 12) >= 6) && ((j % 12) <= 8);
                vectors++;
                if ({o[5], o[4]} !== {wtx, wrx}) begin
                    miscompares++;
                    $display("FAIL cfg_spec[%0d]: got tx=%b rx=%b want tx=%b rx=%b", j, o[5], o[4], wtx, wrx);
                end
                if (j >= 36) begin
                    vectors++;
                    if (o[15:8] !== 8'((j - 36) % 4)) begin
                        miscompares++;
                        $display("FAIL cfg_short_slot[%0d]: got %0d want %0d", j, o[15:8], (j - 36) % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_disable_rst();
        logic [15:0] e, o;
        for (int j = -1; j < 27; j++) begin
            ctrl_en = (j >= 0) && (j != 4); ctrl_master = 1'b1;
            rst = (j == 10);
            if (j < 0) set_cfg(8'd1, 8'd2, 16'd3);
            if (j == 11) set_cfg(8'd5, 8'd9, 16'd2);
            cycle();
        end
        rst = 1'b0;
        for (int j = -1; j < 27; j++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL disable_sb[%0d]: got %h want %h", j, o, e); end
            if (j == 3 || j == 4 || j == 10) begin
                vectors++;
                if ((j == 3 && o[5] !== 1'b1) || (j != 3 && o !== 16'h0000)) begin
                    miscompares++;
                    $display("FAIL disable_zero[%0d]: got %h", j, o);
                end
            end
            if (j == 5 || j == 11) begin
                vectors++;
                if ({o[15:8], o[7], o[0]} !== {8'd0, 1'b1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL disable_restart[%0d]: got slot=%0d fs=%b run=%b want 0 1 1", j, o[15:8], o[7], o[0]);
                end
            end
            if (j >= 15) begin
                vectors++;
                if ({o[5], o[4]} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL slot_range[%0d]: got tx=%b rx=%b want 0 0", j, o[5], o[4]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ctrl_en = 1'b0; ctrl_master = 1'b0; cfg_update = 1'b0;
        sync_in = 1'b0; tx_done = 1'b0;
        cfg_tx_slot = 8'd0; cfg_rx_slot = 8'd0; cfg_tpuint = 16'd0;
        m_state = 0; m_pos = 0; m_T = 1; m_act = '0; m_pend = '0;
        m_ptx = 0; m_prx = 0; m_busy = 0; m_err = 0; m_exp = 16'h0000;
        test_reset();
        test_master();
        test_slave();
        test_overrun();
        test_cfg();
        test_disable_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
